// File: rtl/junction_phase_scheduler.sv
// rtl/junction_phase_scheduler.sv - four-approach traffic phase scheduler
// Round-robin grant, min/max green, yellow and all-red clearance, registered outputs.
module junction_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [7:0] light,
  output logic [3:0] owner,
  output logic       phase_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] own_q, own_d;
  logic [7:0] light_q, light_d;
  logic [3:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic [3:0] competing;
  logic [1:0] lamp;

  // First requesting approach at or after p, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    timer_d   = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    competing = req & ~(4'b0001 << own_q);
    unique case (state_q)
      S_IDLE: begin
        if (req != 4'b0000) begin
          state_d = S_GREEN;
          own_d   = rr_pick(req, ptr_q);
        end
      end
      S_GREEN: begin
        if (timer_q >= 8'(MIN_GREEN - 1) && competing != 4'b0000 &&
            (!req[own_q] || timer_q >= 8'(MAX_GREEN - 1)))
          state_d = S_YELLOW;
      end
      S_YELLOW: begin
        if (timer_q >= 8'(YELLOW_T - 1)) state_d = S_ALLRED;
      end
      S_ALLRED: begin
        if (timer_q >= 8'(ALLRED_T - 1)) begin
          ptr_d = own_q + 2'd1;
          if (req != 4'b0000) begin
            state_d = S_GREEN;
            own_d   = rr_pick(req, own_q + 2'd1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) timer_d = 8'd0;

    // Outputs are derived from the next state so they are registered yet current.
    lamp    = (state_d == S_GREEN)  ? LAMP_GREEN :
              (state_d == S_YELLOW) ? LAMP_YELLOW : LAMP_RED;
    light_d = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (own_d == 2'(i)) light_d[2*i +: 2] = lamp;
    end
    owner_d = (lamp != LAMP_RED) ? (4'b0001 << own_d) : 4'b0000;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= 8'd0;
      ptr_q   <= 2'd0;
      own_q   <= 2'd0;
      light_q <= 8'h00;
      owner_q <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      light_q <= light_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign light      = light_q;
  assign owner      = owner_q;
  assign phase_busy = busy_q;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// tb/tb_junction_phase_scheduler.sv - self-checking bench for junction_phase_scheduler
// Directed scenarios plus random req traffic against a cycle-count phase model.
module tb_junction_phase_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 12;
  localparam int YEL_T = 3;
  localparam int AR_T  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] light;
  logic [3:0] owner;
  logic       phase_busy;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 green, 2 yellow, 3 all-red; served = cycles shown so far in phase.
  int m_phase = 0;
  int m_own = 0;
  int m_ptr = 0;
  int m_served = 0;

  junction_phase_scheduler #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_T(YEL_T), .ALLRED_T(AR_T)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .light(light), .owner(owner), .phase_busy(phase_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int rr(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_own = 0; m_ptr = 0; m_served = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r);
    logic [3:0] others;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (r != 0) begin m_own = rr(r, m_ptr); m_phase = 1; m_served = 0; end
      1: begin
        others = r & ~(4'b0001 << m_own);
        if (m_served >= MIN_G && others != 0 && (!r[m_own] || m_served >= MAX_G)) begin
          m_phase = 2; m_served = 0;
        end
      end
      2: if (m_served >= YEL_T) begin m_phase = 3; m_served = 0; end
      default: if (m_served >= AR_T) begin
        m_ptr = (m_own + 1) % 4;
        m_served = 0;
        if (r != 0) begin m_own = rr(r, m_ptr); m_phase = 1; end
        else m_phase = 0;
      end
    endcase
    if (m_served < 256) m_served++;
  endfunction

  task automatic compare_all(input string tag);
    logic [7:0] el;
    logic [3:0] eo;
    int nz;
    el = 8'h00;
    eo = 4'b0000;
    if (m_phase == 1) el = 8'h02 << (2 * m_own);
    if (m_phase == 2) el = 8'h01 << (2 * m_own);
    if (m_phase == 1 || m_phase == 2) eo = 4'b0001 << m_own;
    check({tag, "_light"}, light, el);
    check({tag, "_owner"}, {4'h0, owner}, {4'h0, eo});
    check({tag, "_busy"}, {7'h0, phase_busy}, {7'h0, m_phase != 0});
    nz = 0;
    for (int i = 0; i < 4; i++) if (light[2*i +: 2] != 2'd0) nz++;
    check({tag, "_excl"}, {7'h0, nz <= 1}, 8'h01);
  endtask

  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    compare_all("tick");
  endtask

  task automatic count_run(input logic [3:0] r, output int n);
    logic [7:0] lv;
    lv = light;
    n = 1;
    for (int i = 0; i < 300; i++) begin
      tick(r);
      if (light !== lv) break;
      n++;
    end
  endtask

  task automatic do_reset(input int cycles);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    for (int i = 0; i < cycles; i++) tick(4'b0000);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int g;
    logic [3:0] r;

    // Reset held 5 cycles with no requests, then a single request on approach 0.
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick(4'b0000);
      check("rst_light", light, 8'h00);
    end
    rst = 1'b0;
    tick(4'b0001);
    check("first_grant_light", light, 8'h02);
    check("first_grant_owner", {4'h0, owner}, 8'h01);

    // Owner keeps requesting, approach 2 competes: max green then yellow, all-red, grant 2.
    tick(4'b0001);
    count_run(4'b0101, n);
    check("maxgreen_len", 8'(n + 1), 8'd12);
    check("yellow_light", light, 8'h01);
    count_run(4'b0101, n);
    check("yellow_len", 8'(n), 8'd3);
    count_run(4'b0101, n);
    check("allred_len", 8'(n), 8'd1);
    check("grant2_light", light, 8'h20);
    check("grant2_owner", {4'h0, owner}, 8'h04);

    // Approach 2 holds to max green against approach 3, reset lands during its yellow.
    count_run(4'b1100, n);
    check("green2_len", 8'(n), 8'd12);
    check("yellow2_light", light, 8'h10);
    do_reset(2);
    check("rst_mid_light", light, 8'h00);
    check("rst_mid_owner", {4'h0, owner}, 8'h00);

    // All four request from release: 0,1,2,3,0, each green MAX_G.
    for (int k = 0; k < 5; k++) begin
      if (k == 0) tick(4'b1111);
      check("rr_owner", {4'h0, owner}, 8'(4'b0001 << (k % 4)));
      if (k < 4) begin
        count_run(4'b1111, n);
        check("rr_green_len", 8'(n), 8'd12);
        count_run(4'b1111, n);
        check("rr_yellow_len", 8'(n), 8'd3);
        count_run(4'b1111, n);
        check("rr_allred_len", 8'(n), 8'd1);
      end
    end

    // Approach 1 drops its request at once, approach 3 waits: min green only.
    do_reset(1);
    tick(4'b0010);
    check("a1_light", light, 8'h08);
    count_run(4'b1000, n);
    check("mingreen_len", 8'(n), 8'd4);

    // Lone requester rests on green.
    do_reset(1);
    tick(4'b0001);
    g = 0;
    for (int i = 0; i < 50; i++) begin
      if (light === 8'h02) g++;
      tick(4'b0001);
    end
    check("rest_green_cycles", 8'(g), 8'd50);

    // Random level traffic with occasional resets.
    do_reset(1);
    r = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
      tick(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/junction_phase_scheduler.md
JUNCTION_PHASE_SCHEDULER -- requirements
Module: junction_phase_scheduler

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 4: minimum cycles a granted approach stays GREEN.
REQ-002 The block SHALL have parameter MAX_GREEN, default 12: cycles after which a GREEN approach yields to a competing request; MAX_GREEN >= MIN_GREEN >= 1.
REQ-003 The block SHALL have parameter YELLOW_T, default 3: YELLOW duration in cycles, >= 1.
REQ-004 The block SHALL have parameter ALLRED_T, default 1: all-red clearance duration in cycles, >= 1.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port req, input, 4 bits: level vehicle sensor per approach, bit i = approach i, synchronous to clk.
REQ-008 The block SHALL have port light, output, 8 bits: light[2i+1:2i] = lamp of approach i; encoding 0 = RED, 1 = YELLOW, 2 = GREEN, 3 unused.
REQ-009 The block SHALL have port owner, output, 4 bits: one-hot approach currently in GREEN or YELLOW, 0 otherwise.
REQ-010 The block SHALL have port phase_busy, output, 1 bit: high in GREEN, YELLOW and ALLRED states.

Function
REQ-011 The block SHALL implement states IDLE, GREEN, YELLOW and ALLRED, with one 8-bit phase timer cleared on every state entry and incremented each cycle in state.
REQ-012 All outputs SHALL be registered and SHALL change only on a clk rising edge or on rst assertion.
REQ-013 In IDLE, all lamps SHALL be RED, owner = 0 and phase_busy = 0.
REQ-014 In IDLE, when req != 0 at a rising edge, the block SHALL select the winner by round-robin starting from pointer ptr, and SHALL show that approach GREEN from the same edge (1-cycle latency from req sample to GREEN).
REQ-015 In GREEN, only the owner lamp SHALL be GREEN; all others SHALL be RED.
REQ-016 GREEN SHALL end when timer >= MIN_GREEN-1, a non-owner req bit is high, and either the owner req bit is low or timer >= MAX_GREEN-1.
REQ-017 With no competing request, GREEN SHALL be held indefinitely (rest on green), regardless of MAX_GREEN.
REQ-018 On GREEN exit, the owner lamp SHALL be YELLOW for exactly YELLOW_T cycles.
REQ-019 After YELLOW, all lamps SHALL be RED for exactly ALLRED_T cycles, with owner = 0 and phase_busy = 1.
REQ-020 On ALLRED exit, ptr SHALL be set to (previous owner index + 1) mod 4.
REQ-021 On ALLRED exit, the block SHALL grant the round-robin winner from ptr, or go to IDLE if req = 0.
REQ-022 The previous owner SHALL be eligible at ALLRED exit only if no other approach requests.
REQ-023 Two approaches SHALL never be non-RED in the same cycle.
REQ-024 A req pulse that drops before it is sampled in IDLE or at ALLRED exit SHALL be ignored; the block keeps no request latching.
REQ-025 Simultaneous requests SHALL be resolved solely by ptr order (ptr, ptr+1, ptr+2, ptr+3 mod 4).
REQ-026 The timer SHALL saturate at 255 and never wrap.

Reset
REQ-027 While rst is high, the block SHALL be in IDLE, with light = 8'h00, owner = 0, phase_busy = 0, ptr = 0 and timer = 0.
REQ-028 rst asserted mid-phase SHALL force all lamps RED immediately, without a YELLOW or ALLRED sequence.
REQ-029 After rst deasserts, the first rising edge SHALL evaluate the IDLE grant rule.

Verification
REQ-030 Bench SHALL cover: rst held 5 cycles, req = 0 -> light = 00, owner = 0 throughout; then req = 4'b0001 -> light = 8'h02, owner = 0001 one edge later.
REQ-031 Bench SHALL cover: approach 0 GREEN with req0 high, req2 raised at GREEN cycle 1 -> GREEN until 12 cycles elapsed, 3 cycles YELLOW (light = 8'h01), 1 cycle all-red, then light = 8'h20, owner = 0100.
REQ-032 Bench SHALL cover: approach 1 GREEN, req1 dropped at cycle 0, req3 high -> YELLOW begins after exactly 4 GREEN cycles.
REQ-033 Bench SHALL cover: req = 4'b1111 held from reset -> grant order 0, 1, 2, 3, 0; each GREEN lasts 12 cycles; no cycle has two non-RED lamps.
REQ-034 Bench SHALL cover: only req0 high for 50 cycles -> approach 0 stays GREEN all 50 cycles, with no YELLOW.
REQ-035 Bench SHALL cover: rst pulsed during YELLOW of approach 2 -> light = 00 in the same cycle, owner = 0, and ptr = 0 on release.
